// File: rtl/serdes_tx_arbiter.sv
// serdes_tx_arbiter: two-requester packet framer for SERDES TX (header, payload, optional checksum trailer via SERDES_TX_ARB_CHECKSUM_EN)
module serdes_tx_arbiter #(
  parameter int MAX_PKT   = 1024,
  parameter int CNT_WIDTH = 11
) (
  input  logic        dsp_clk,
  input  logic        dsp_rst,
  input  logic [15:0] req0_dat,
  input  logic        req0_last,
  input  logic        req0_valid,
  output logic        req0_rdy,
  input  logic [15:0] req1_dat,
  input  logic        req1_last,
  input  logic        req1_valid,
  output logic        req1_rdy,
  output logic [15:0] tx_dat_o,
  output logic        tx_klsb_o,
  output logic        tx_kmsb_o,
  output logic        tx_en_o,
  input  logic        tx_rdy_i,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        pkt_err,
  output logic [7:0]  debug
);
  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;
  state_t state, state_nxt;
  logic ch, ch_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic err_q, err_nxt;
  logic [15:0] dat, src_dat;
  logic klsb, en, rdy, src_valid, src_last, busy_r;
  logic [1:0] grant_r;
`ifdef SERDES_TX_ARB_CHECKSUM_EN
  logic [15:0] sum, sum_nxt;
`endif
  assign src_dat   = ch ? req1_dat : req0_dat;
  assign src_valid = ch ? req1_valid : req0_valid;
  assign src_last  = ch ? req1_last : req0_last;
  assign cnt_inc   = cnt + CNT_WIDTH'(1);
  always_comb begin
    state_nxt = state;
    ch_nxt = ch;
    cnt_nxt = cnt;
    err_nxt = err_q;
    dat = '0;
    klsb = 1'b0;
    en = 1'b0;
    rdy = 1'b0;
`ifdef SERDES_TX_ARB_CHECKSUM_EN
    sum_nxt = sum;
`endif
    case (state)
      IDLE: if (req0_valid | req1_valid) begin
        ch_nxt = (req0_valid & req1_valid) ? ~ch : req1_valid;
        state_nxt = HDR;
      end
      HDR: begin
        dat = {7'b0, ch, 8'h5C};
        klsb = 1'b1;
        en = tx_rdy_i;
        if (tx_rdy_i) begin
          cnt_nxt = '0;
`ifdef SERDES_TX_ARB_CHECKSUM_EN
          sum_nxt = '0;
`endif
          state_nxt = DATA;
        end
      end
      DATA: begin
        dat = src_dat;
        rdy = tx_rdy_i;
        en = src_valid & tx_rdy_i;
        if (en) begin
          cnt_nxt = cnt_inc;
`ifdef SERDES_TX_ARB_CHECKSUM_EN
          sum_nxt = sum ^ src_dat;
`endif
          if (src_last || cnt_inc == CNT_WIDTH'(MAX_PKT)) begin
            err_nxt = err_q | ~src_last;
`ifdef SERDES_TX_ARB_CHECKSUM_EN
            state_nxt = TRL;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
      TRL: begin
`ifdef SERDES_TX_ARB_CHECKSUM_EN
        dat = sum;
        en = tx_rdy_i;
        if (tx_rdy_i) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
    endcase
  end
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      state <= IDLE;
      ch <= 1'b1;
      cnt <= '0;
      err_q <= 1'b0;
`ifdef SERDES_TX_ARB_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= state_nxt;
      ch <= ch_nxt;
      cnt <= cnt_nxt;
      err_q <= err_nxt;
`ifdef SERDES_TX_ARB_CHECKSUM_EN
      sum <= sum_nxt;
`endif
    end
  end
  assign busy_r    = state != IDLE;
  assign grant_r   = busy_r ? {ch, ~ch} : 2'b00;
  assign req0_rdy  = rdy & ~ch & ~dsp_rst;
  assign req1_rdy  = rdy & ch & ~dsp_rst;
  assign tx_en_o   = en & ~dsp_rst;
  assign tx_dat_o  = dsp_rst ? 16'h0 : dat;
  assign tx_klsb_o = klsb & ~dsp_rst;
  assign tx_kmsb_o = 1'b0;
  assign grant     = dsp_rst ? 2'b00 : grant_r;
  assign busy      = busy_r & ~dsp_rst;
  assign pkt_err   = err_q & ~dsp_rst;
  assign debug     = dsp_rst ? 8'h00 : {err_q, busy_r, grant_r, ch, 1'b0, state};
endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// tb_serdes_tx_arbiter: scoreboard bench for serdes_tx_arbiter with MAX_PKT=4
module tb_serdes_tx_arbiter;
  localparam int MAX_PKT = 4;
  logic dsp_clk = 1'b0;
  logic dsp_rst = 1'b1;
  logic [15:0] req0_dat, req1_dat, tx_dat_o;
  logic req0_last, req0_valid, req0_rdy, req1_last, req1_valid, req1_rdy;
  logic tx_klsb_o, tx_kmsb_o, tx_en_o, tx_rdy_i, busy, pkt_err;
  logic [1:0] grant;
  logic [7:0] debug;
  logic [16:0] q0[$], q1[$];
  logic [17:0] exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit toggle = 1'b0, acc0, acc1;
  always #5 dsp_clk = ~dsp_clk;
  serdes_tx_arbiter #(.MAX_PKT(MAX_PKT), .CNT_WIDTH(3)) dut (
    .dsp_clk(dsp_clk), .dsp_rst(dsp_rst),
    .req0_dat(req0_dat), .req0_last(req0_last), .req0_valid(req0_valid), .req0_rdy(req0_rdy),
    .req1_dat(req1_dat), .req1_last(req1_last), .req1_valid(req1_valid), .req1_rdy(req1_rdy),
    .tx_dat_o(tx_dat_o), .tx_klsb_o(tx_klsb_o), .tx_kmsb_o(tx_kmsb_o), .tx_en_o(tx_en_o),
    .tx_rdy_i(tx_rdy_i), .grant(grant), .busy(busy), .pkt_err(pkt_err), .debug(debug)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive();
    req0_valid = q0.size() > 0;
    req0_dat = 16'h0;
    req0_last = 1'b0;
    if (req0_valid) {req0_last, req0_dat} = q0[0];
    req1_valid = q1.size() > 0;
    req1_dat = 16'h0;
    req1_last = 1'b0;
    if (req1_valid) {req1_last, req1_dat} = q1[0];
    tx_rdy_i = toggle ? cyc[0] : 1'b1;
  endtask
  task automatic cycle();
    drive();
    @(negedge dsp_clk);
    acc0 = req0_valid & req0_rdy;
    acc1 = req1_valid & req1_rdy;
    if (dsp_rst)
      chk("rst_out", {tx_en_o, req0_rdy, req1_rdy, tx_dat_o, tx_klsb_o, tx_kmsb_o, grant, busy, pkt_err, debug}, 64'h0);
    else begin
      if (!tx_rdy_i) chk("stall", {tx_en_o, req0_rdy, req1_rdy}, 64'h0);
      chk("rdy_owner", {req0_rdy & ~grant[0], req1_rdy & ~grant[1]}, 64'h0);
      if (tx_en_o) begin
        if (exp_q.size() == 0) chk("tx_extra", tx_en_o, 64'h0);
        else chk("tx_word", {tx_kmsb_o, tx_klsb_o, tx_dat_o}, exp_q.pop_front());
      end
    end
    @(posedge dsp_clk);
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    cyc++;
  endtask
  task automatic send(input int ch, input int n, input logic [15:0] base, input logic [15:0] step, input bit last);
    int cnt;
    logic [15:0] sum, w;
    bit l;
    cnt = 0;
    sum = 16'h0;
    for (int i = 0; i < n; i++) begin
      w = base + step * 16'(i);
      l = last && (i == n - 1);
      if (ch == 0) q0.push_back({l, w});
      else q1.push_back({l, w});
      if (cnt == 0) begin
        exp_q.push_back({2'b01, 7'b0, ch[0], 8'h5C});
        sum = 16'h0;
      end
      exp_q.push_back({2'b00, w});
      sum ^= w;
      cnt++;
      if (l || cnt == MAX_PKT) begin
`ifdef SERDES_TX_ARB_CHECKSUM_EN
        exp_q.push_back({2'b00, sum});
`endif
        cnt = 0;
      end
    end
  endtask
  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget && (exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || busy)) begin
      cycle();
      k++;
    end
    chk("drain", exp_q.size(), 64'h0);
    chk("drain_busy", busy, 64'h0);
  endtask
  initial begin
    int k;
    cycle();
    cycle();
    dsp_rst = 1'b0;
    cycle();
    chk("rst_debug", debug, 64'h08);
    send(0, 2, 16'h1111, 16'h1111, 1'b1);
    wait_idle(50);
    chk("idle_debug", debug, 64'h00);
    dsp_rst = 1'b1;
    cycle();
    dsp_rst = 1'b0;
    send(0, 1, 16'h0010, 16'h1, 1'b1);
    send(1, 2, 16'h0020, 16'h1, 1'b1);
    send(0, 2, 16'h0030, 16'h1, 1'b1);
    send(1, 1, 16'h0040, 16'h1, 1'b1);
    wait_idle(100);
    toggle = 1'b1;
    send(0, 4, 16'h0a31, 16'h0101, 1'b1);
    wait_idle(100);
    toggle = 1'b0;
    chk("no_err", pkt_err, 64'h0);
    send(1, 6, 16'h0041, 16'h1, 1'b1);
    wait_idle(100);
    chk("pkt_err", pkt_err, 64'h1);
    chk("err_debug", debug, 64'h88);
    send(0, 4, 16'h0051, 16'h1, 1'b1);
    k = 0;
    while (q0.size() > 2 && k < 50) begin
      cycle();
      k++;
    end
    chk("in_data", debug[1:0], 64'h2);
    dsp_rst = 1'b1;
    cycle();
    dsp_rst = 1'b0;
    chk("rst_kept_words", q0.size(), 64'h2);
    q0.delete();
    exp_q.delete();
    cycle();
    chk("post_rst", debug, 64'h08);
    send(0, 2, 16'h0053, 16'h1, 1'b1);
    send(1, 1, 16'h0060, 16'h1, 1'b1);
    wait_idle(100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
